// File: rtl/systemx_pkg.sv
// Shared definitions for the SystemX BIST checker: state encoding, defaults
// and a saturating increment used by the mismatch counter.
package systemx_pkg;

    localparam int DEF_NUM_INPUTS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Increments v unless its low w bits are already all-ones (1 <= w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - w);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/systemx_bist_checker_settle_timer.sv
// Loadable settle counter; expire_o pulses in the cycle the count reaches LIMIT-1
// while counting is enabled.
module systemx_settle_timer #(
    parameter int LIMIT = 2,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/systemx_bist_checker.sv
// Sweeps all input vectors into two SystemX implementations, compares their F
// outputs after settling, counts mismatches and captures the first failing vector.
module systemx_bist_checker
    import systemx_pkg::*;
#(
    parameter int NUM_INPUTS    = DEF_NUM_INPUTS,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [NUM_INPUTS-1:0] abc_out,
    input  logic                  f_0,
    input  logic                  f_1,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  first_err_valid,
    output logic [NUM_INPUTS-1:0] first_err_vec
);

    state_e                state_q, state_d;
    logic [NUM_INPUTS-1:0] vec_q, vec_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  fev_q, fev_d;
    logic [NUM_INPUTS-1:0] fvec_q, fvec_d;
    logic                  pass_q, pass_d;
    logic                  tmr_load, tmr_en, tmr_expire;

    systemx_settle_timer #(
        .LIMIT (SETTLE_CYCLES),
        .CNT_W (4)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vec_d    = '0;
                err_d    = '0;
                fev_d    = 1'b0;
                fvec_d   = '0;
                pass_d   = 1'b0;
                tmr_load = 1'b1;
                if (start)
                    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expire)
                    state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (f_0 != f_1) begin
                    err_d = ERR_CNT_W'(sat_inc(32'(err_q), ERR_CNT_W));
                    if (!fev_q) begin
                        fev_d  = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (vec_q == '1) begin
                    state_d = ST_DONE;
                    vec_d   = '0;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d  = ST_SETTLE;
                    vec_d    = vec_q + NUM_INPUTS'(1);
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                // Results are frozen here; a new start clears exactly as IDLE does.
                if (start) begin
                    state_d  = ST_SETTLE;
                    vec_d    = '0;
                    err_d    = '0;
                    fev_d    = 1'b0;
                    fvec_d   = '0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fvec_q  <= fvec_d;
            pass_q  <= pass_d;
        end
    end

    assign abc_out         = vec_q;
    assign busy            = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;

endmodule
